pwm_capture: RTL
================

// Module: pwm_capture
//
// PURPOSE
//  Measures an external PWM/servo pulse train, the inverse of the periodic tick
//  generators: it turns a pulse stream back into timing numbers.
//  Reports high-time and period in microseconds for one RC receiver channel.
//  One instance per channel sits beside the timer block on the avionics board.
//  A 1-cycle strobe hands each completed measurement to the register/telemetry logic.
//
// PARAMETERS
//  CLK_PER_US  50     clk cycles per microsecond tick (50 MHz clk); must be >= 2
//  CW          16     width of width_us/period_us and internal us counters
//  TIMEOUT_US  25000  us without a rising edge before the channel is declared lost
//
// PORTS
//  clk        in   1   system clock; the block uses this one clock only
//  rst        in   1   asynchronous, active-high reset
//  pwm_in     in   1   raw asynchronous PWM input pin
//  width_us   out  CW  last complete high-time in us
//  period_us  out  CW  last complete rising-to-rising period in us
//  valid      out  1   1-cycle strobe: width_us/period_us just updated
//  timeout    out  1   level: no rising edge for TIMEOUT_US
//
// BEHAVIOUR
//  Reset values: width_us=0, period_us=0, valid=0, timeout=0, FSM=WAIT.
//  Reset drives all internal counters and synchronizer flops to 0.
//  Input sync: 2-FF synchronizer, then a registered edge detect -> rise/fall pulses.
//  Pin-to-edge-pulse latency is 3 clk.
//  us tick: prescaler counts 0..CLK_PER_US-1 and emits a tick on wrap.
//   The prescaler is forced to 0 on every detected rise.
//   Result: width = floor(high_clks / CLK_PER_US), and likewise for the period.
//  Counters: hi_cnt counts ticks while in HIGH. per_cnt counts ticks in HIGH and LOW.
//   Both saturate at 2^CW-1 and never wrap.
//  FSM:
//   WAIT: on rise, clear hi_cnt/per_cnt and go to HIGH. No valid is produced from WAIT.
//   HIGH: on fall, latch hi_cnt into a width holding register and go to LOW.
//   LOW:  on rise, drive width_us<=held width and period_us<=per_cnt in the same cycle.
//         In that cycle: valid=1, counters cleared, FSM goes to HIGH.
//  valid rises exactly 1 clk after the rise pulse is seen (pin->valid = 4 clk).
//  Timeout: a separate us counter is cleared on every rise and increments on ticks.
//   When it reaches TIMEOUT_US, in any state: timeout=1, FSM goes to WAIT.
//   width_us and period_us are cleared to 0.
//   timeout stays 1 until the next valid, and clears in the same cycle valid=1.
//  Simultaneous events: rise and timeout in the same cycle -> rise wins.
//   In that case the timeout counter clears and timeout does not assert.
//  A fall seen in WAIT or LOW is ignored; a rise in HIGH cannot occur (edges alternate).
//  Reset mid-pulse: measurement is discarded and the FSM restarts in WAIT.
//   The first full period after reset produces no valid.
//  Constant high input: no rise ever arrives, so the timeout fires.
//
// STRUCTURE
//  Shared include avionics_defs.vh: CLK_HZ (50_000_000), CLK_PER_US,
//   FSM state encodings (WAIT=2'd0, HIGH=2'd1, LOW=2'd2).
//  Sub-module edge_sync (clk, rst, d_in -> rise, fall).
//   It holds the 2-FF synchronizer and the registered edge detect.
//   It is reused by the other board input capture blocks.
//  Top level holds the prescaler, hi/per/timeout counters, FSM and output registers.
//
// TESTING
//  1) Reset, then pulses: 1500 us high / 20000 us period, x3.
//     -> No valid on the first rise.
//     -> Two valid strobes, each with width_us=1500, period_us=20000.
//  2) Width sweep 1000/2000 us at a 50 Hz frame.
//     -> Each valid reports the exact width; the valid pulse is one clk wide.
//  3) High of 1500 us + 37 clk.
//     -> width_us=1500 (floor); valid is 4 clk after the pin rise.
//  4) Stop input low after a valid.
//     -> timeout=1 exactly TIMEOUT_US after the last rise; outputs go to 0.
//     -> Resume pulses: the first rise gives no valid, the second gives valid and clears timeout.
//  5) Assert rst during the HIGH phase, then release.
//     -> All outputs are 0 immediately (async); the next valid comes only after two rises.
//  6) CW=8, 400 us high pulse -> width_us=255 (saturated), period_us=255.
//     No timeout if the period is below TIMEOUT_US.

Source files
------------

// File: rtl/pwm_capture_pkg.sv
// Shared board-level definitions for the input capture blocks: the system clock
// rate and the capture FSM state encoding.
package pwm_capture_pkg;

  localparam int CLK_HZ     = 50_000_000;
  localparam int CLK_PER_US = CLK_HZ / 1_000_000;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_capture_edge_sync.sv
// Two-flop synchronizer for an asynchronous pin followed by a registered edge
// detector. The rise/fall pulses appear 3 clk after the pin changes.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic rise,
  output logic fall
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic s3_q, s3_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    s1_d   = d_in;
    s2_d   = s1_q;
    s3_d   = s2_q;
    rise_d = s2_q & ~s3_q;
    fall_d = ~s2_q & s3_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      s3_q   <= s3_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures high-time and rising-to-rising period of one PWM/servo channel in
// microseconds, with a 1-cycle result strobe and a lost-signal timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CLK_PER_US = pwm_capture_pkg::CLK_PER_US,
  parameter int CW         = 16,
  parameter int TIMEOUT_US = 25000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pwm_in,
  output logic [CW-1:0] width_us,
  output logic [CW-1:0] period_us,
  output logic          valid,
  output logic          timeout
);

  localparam int PW = $clog2(CLK_PER_US);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_US - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_US - 1);
  localparam logic [TW-1:0] TO_FULL  = TW'(TIMEOUT_US);

  logic rise, fall;

  edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d_in (pwm_in),
    .rise (rise),
    .fall (fall)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   hi_q, hi_d;
  logic [CW-1:0]   per_q, per_d;
  logic [CW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   to_q, to_d;
  logic [CW-1:0]   width_q, width_d;
  logic [CW-1:0]   period_q, period_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            tick, to_hit;
  logic [CW-1:0]   hi_inc, per_inc;

  // NOTE: every signal gets a default at the top of the block so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    // Latching the incremented value counts a tick that lands on the edge
    // cycle itself, which makes the result floor(clks / CLK_PER_US).
    hi_inc    = (tick && hi_q != CNT_MAX) ? hi_q + CW'(1) : hi_q;
    per_inc   = (tick && per_q != CNT_MAX) ? per_q + CW'(1) : per_q;
    to_hit    = tick && (to_q == TO_LAST);

    pre_d     = tick ? '0 : pre_q + PW'(1);
    to_d      = (tick && to_q != TO_FULL) ? to_q + TW'(1) : to_q;
    state_d   = state_q;
    hi_d      = hi_q;
    per_d     = per_q;
    hold_d    = hold_q;
    width_d   = width_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    unique case (state_q)
      ST_WAIT: begin
        if (rise) begin
          hi_d    = '0;
          per_d   = '0;
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        hi_d  = hi_inc;
        per_d = per_inc;
        if (fall) begin
          hold_d  = hi_inc;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        per_d = per_inc;
        if (rise) begin
          width_d   = hold_q;
          period_d  = per_inc;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          hi_d      = '0;
          per_d     = '0;
          state_d   = ST_HIGH;
        end
      end
      default: state_d = ST_WAIT;
    endcase

    // A rise on the same cycle as the timeout wins and re-arms the counter.
    if (rise) begin
      pre_d = '0;
      to_d  = '0;
    end else if (to_hit) begin
      timeout_d = 1'b1;
      state_d   = ST_WAIT;
      width_d   = '0;
      period_d  = '0;
    end
  end

  // NOTE: all counters and holding registers are reset along with the control
  // state so a restart never reports a stale partial measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_WAIT;
      pre_q     <= '0;
      hi_q      <= '0;
      per_q     <= '0;
      hold_q    <= '0;
      to_q      <= '0;
      width_q   <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      hi_q      <= hi_d;
      per_q     <= per_d;
      hold_q    <= hold_d;
      to_q      <= to_d;
      width_q   <= width_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign width_us  = width_q;
  assign period_us = period_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;

endmodule
